instr_packer: RTL and testbench
===============================

Name: instr_packer

Overview:
Inverse of the instruction field decode path: takes separated MIPS instruction fields plus a format select and packs them into 32-bit instruction words. Each packed word is emitted through a valid/ready write port toward instruction memory, with an auto-incrementing write address. Used by the test loader and the boot-time program writer to fill instruction memory sequentially from a base address.

Parameters:
ADDR_W, 8, width of the word address into instruction memory
BASE_ADDR, 0, word address loaded on start
DEPTH, 256, maximum words written per load session (1..2^ADDR_W)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: begin/restart a load session
in_valid  input  1  field bundle valid
in_ready  output  1  packer accepts bundle this cycle
fmt  input  2  0=R, 1=I, 2=J, 3=illegal
opCode  input  6  opcode field (ignored for R)
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R only)
shamt  input  5  shift amount (R only)
funct  input  6  function code (R only)
imm  input  16  immediate/offset (I only)
target  input  26  jump target (J only)
out_valid  output  1  packed word valid
out_ready  input  1  memory accepts word
out_addr  output  ADDR_W  word address of out_data
out_data  output  32  packed instruction
count  output  ADDR_W+1  words written this session
err  output  1  sticky: illegal fmt seen this session
done  output  1  session full and drained

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, out_addr=0, out_data=0, count=0, err=0, done=0, in_ready=0.
- Packing (all fixed, no configurable layout):
  R: {6'b000000, rs, rt, rd, shamt, funct}, i.e. rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]; the opCode input is ignored.
  I: {opCode, rs, rt, imm}.
  J: {opCode, target}.
- FSM states and transitions:
  IDLE: in_ready=0. start moves to RUN.
  RUN: accepts bundles. Moves to FULL once the DEPTH-th word has been accepted.
  FULL: in_ready=0. done=1 once out_valid=0. start moves to RUN.
- Entering RUN via start, on the next edge: write pointer=BASE_ADDR, count=0, err=0, done=0, out_valid=0. Any pending word is dropped.
- in_ready = (state==RUN) && !start && (!out_valid || out_ready). The signal is combinational; no dependence of in_valid on in_ready is permitted.
- Accept (in_valid && in_ready) with legal fmt:
  - Next edge: out_data=packed word, out_addr=write pointer, out_valid=1.
  - Write pointer increments modulo 2^ADDR_W (wraps silently).
  - count increments.
  - Latency: 1 cycle from accept to out_valid.
- Accept with fmt=3: bundle consumed, no word emitted, err set (sticky until start or reset), pointer and count unchanged.
- Output handshake:
  - out_valid && out_ready retires the word.
  - If no new accept occurs in that cycle, out_valid clears next edge.
  - Retire and accept in the same cycle replace the word back-to-back, sustaining 1 word/cycle.
  - While out_valid && !out_ready, out_data and out_addr hold stable.
- Full condition: the accept that makes count==DEPTH also transitions to FULL. That last word still drains normally.
- start has priority over every in-flight event in the same cycle.
- start while in RUN is a restart, not ignored.
- Reset asserted mid-operation clears all state immediately; the pending word is lost.

Test Plan:
- R pack: start; fmt=0, opCode=6'h3F (must be ignored), rs=1, rt=2, rd=3, shamt=0, funct=6'h20, out_ready=1 -> next cycle out_valid=1, out_data=32'h00221820, out_addr=0, count=1.
- I/J pack back-to-back: fmt=1 lw opCode=6'h23, rs=29, rt=8, imm=16'h0004, then fmt=2 opCode=6'h02, target=26'h0100000 -> 32'h8FA80004 at addr 0, then 32'h08100000 at addr 1 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after the first accept, out_data/out_addr stable; release -> one word per cycle, no loss or duplication.
- Illegal format and full: DEPTH=4, BASE_ADDR=254, ADDR_W=8; send 2 legal, 1 fmt=3, 2 legal:
  - Addresses 254, 255, 0, 1.
  - err=1, count=4, state FULL, in_ready=0.
  - done=1 after the final retire.
- Restart and reset: start pulsed while out_valid=1 and out_ready=0 -> word dropped, count=0, err=0, next word at BASE_ADDR; rst_n low mid-session -> all outputs 0 immediately without a clock edge.

Source files
------------

// File: rtl/instr_packer.sv
// Packs separated MIPS R/I/J fields into 32-bit words and streams them,
// with auto-incrementing addresses, through a valid/ready port to imem.
module instr_packer #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opCode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FULL
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [ADDR_W-1:0]  ptr;
  logic [31:0]        word;
  logic               acc;
  logic               legal;
  logic               last;

  assign in_ready = (state == RUN) && !start
                  && (!out_valid || out_ready);
  assign acc   = in_valid && in_ready;
  assign legal = (fmt != 2'd3);
  assign last  = acc && legal
               && (count == CNT_W'(DEPTH - 1));
  assign done  = (state == FULL) && !out_valid;

  always_comb begin
    word = 32'd0;
    unique case (fmt)
      2'd0:    word = {6'b0, rs, rt, rd, shamt, funct};
      2'd1:    word = {opCode, rs, rt, imm};
      2'd2:    word = {opCode, target};
      default: word = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN: begin
        if (start)     state_nx = RUN;
        else if (last) state_nx = FULL;
      end
      FULL:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= ADDR_W'(BASE_ADDR);
      count     <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= 32'd0;
    end else if (start) begin
      ptr       <= ADDR_W'(BASE_ADDR);
      count     <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (acc && legal) begin
        out_valid <= 1'b1;
        out_data  <= word;
        out_addr  <= ptr;
        ptr       <= ptr + ADDR_W'(1);
        count     <= count + CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // illegal bundles are swallowed; only the flag remembers them
      if (acc && !legal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer: a default instance (base 0, depth 256)
// and a small instance (base 254, depth 4) share the field inputs.
module tb_instr_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic        in_valid;
  logic [1:0]  fmt;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, err_a, done_a;
  logic [7:0]  out_addr_a;
  logic [31:0] out_data_a;
  logic [8:0]  count_a;

  logic        in_ready_b, out_valid_b, err_b, done_b;
  logic [7:0]  out_addr_b;
  logic [31:0] out_data_b;
  logic [8:0]  count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_packer u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .fmt(fmt), .opCode(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_addr(out_addr_a), .out_data(out_data_a),
    .count(count_a), .err(err_a), .done(done_a)
  );

  instr_packer #(.ADDR_W(8), .BASE_ADDR(254), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .fmt(fmt), .opCode(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_addr(out_addr_b), .out_data(out_data_b),
    .count(count_b), .err(err_b), .done(done_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input logic [15:0] v);
    fmt = 2'd1; op = 6'h23; rs = 5'd29; rt = 5'd8; imm = v;
  endtask

  task automatic set_j(input logic [25:0] v);
    fmt = 2'd2; op = 6'h02; target = v;
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    fmt = 2'd0; op = 6'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
    shamt = 5'd0; funct = 6'd0; imm = 16'd0; target = 26'd0;
    #12;
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    chk("rst_data", out_data_a, 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    in_valid = 1'b1; #1;
    chk("idle_rdy", 32'(in_ready_a), 32'd0);
    in_valid = 1'b0;

    // R pack, opCode must be ignored
    start_a = 1'b1; tick(); start_a = 1'b0;
    fmt = 2'd0; op = 6'h3F; rs = 5'd1; rt = 5'd2; rd = 5'd3;
    shamt = 5'd0; funct = 6'h20; out_ready = 1'b1; in_valid = 1'b1;
    #1 chk("r_rdy", 32'(in_ready_a), 32'd1);
    tick(); in_valid = 1'b0;
    chk("r_valid", 32'(out_valid_a), 32'd1);
    chk("r_data", out_data_a, 32'h00221820);
    chk("r_addr", 32'(out_addr_a), 32'd0);
    chk("r_count", 32'(count_a), 32'd1);
    tick();
    chk("r_clear", 32'(out_valid_a), 32'd0);

    // I then J back to back from a fresh session
    start_a = 1'b1; tick(); start_a = 1'b0;
    set_i(16'h0004); in_valid = 1'b1;
    tick(); set_j(26'h0100000);
    chk("i_data", out_data_a, 32'h8FA80004);
    chk("i_addr", 32'(out_addr_a), 32'd0);
    chk("i_rdy", 32'(in_ready_a), 32'd1);
    tick(); in_valid = 1'b0;
    chk("j_data", out_data_a, 32'h08100000);
    chk("j_addr", 32'(out_addr_a), 32'd1);
    chk("j_count", 32'(count_a), 32'd2);
    tick();

    // backpressure
    set_i(16'h0010); in_valid = 1'b1; out_ready = 1'b0;
    tick(); set_i(16'h0020);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdy", 32'(in_ready_a), 32'd0);
      chk("bp_data", out_data_a, 32'h8FA80010);
      chk("bp_addr", 32'(out_addr_a), 32'd2);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_rel_rdy", 32'(in_ready_a), 32'd1);
    tick(); set_i(16'h0030);
    chk("bp_b_data", out_data_a, 32'h8FA80020);
    chk("bp_b_addr", 32'(out_addr_a), 32'd3);
    tick(); in_valid = 1'b0;
    chk("bp_c_data", out_data_a, 32'h8FA80030);
    chk("bp_c_addr", 32'(out_addr_a), 32'd4);
    chk("bp_count", 32'(count_a), 32'd5);
    tick();
    chk("bp_drain", 32'(out_valid_a), 32'd0);

    // small instance: wrap, illegal format, full
    start_b = 1'b1; tick(); start_b = 1'b0;
    set_j(26'd1); in_valid = 1'b1;
    tick(); set_j(26'd2);
    chk("s1_addr", 32'(out_addr_b), 32'd254);
    chk("s1_data", out_data_b, 32'h08000001);
    tick(); fmt = 2'd3;
    chk("s2_addr", 32'(out_addr_b), 32'd255);
    tick(); set_j(26'd3);
    chk("ill_valid", 32'(out_valid_b), 32'd0);
    chk("ill_err", 32'(err_b), 32'd1);
    chk("ill_count", 32'(count_b), 32'd2);
    tick(); set_j(26'd4);
    chk("s3_addr", 32'(out_addr_b), 32'd0);
    chk("s3_data", out_data_b, 32'h08000003);
    tick();
    chk("s4_addr", 32'(out_addr_b), 32'd1);
    chk("s4_count", 32'(count_b), 32'd4);
    chk("full_rdy", 32'(in_ready_b), 32'd0);
    chk("full_nodone", 32'(done_b), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("full_done", 32'(done_b), 32'd1);
    chk("full_err", 32'(err_b), 32'd1);

    // restart drops a stalled word
    set_i(16'h00AA); in_valid = 1'b1; out_ready = 1'b0;
    tick(); set_i(16'h00BB);
    chk("rs_pend", 32'(out_valid_a), 32'd1);
    start_a = 1'b1; #1;
    chk("rs_rdy", 32'(in_ready_a), 32'd0);
    tick(); start_a = 1'b0;
    chk("rs_valid", 32'(out_valid_a), 32'd0);
    chk("rs_count", 32'(count_a), 32'd0);
    chk("rs_err", 32'(err_a), 32'd0);
    out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    chk("rs_addr", 32'(out_addr_a), 32'd0);
    chk("rs_data", out_data_a, 32'h8FA800BB);
    chk("rs_count1", 32'(count_a), 32'd1);

    // async reset mid-session
    #2 rst_n = 1'b0; #1;
    chk("ar_valid", 32'(out_valid_a), 32'd0);
    chk("ar_addr", 32'(out_addr_a), 32'd0);
    chk("ar_data", out_data_a, 32'd0);
    chk("ar_count", 32'(count_a), 32'd0);
    chk("ar_err", 32'(err_b), 32'd0);
    chk("ar_done", 32'(done_b), 32'd0);
    chk("ar_cnt_b", 32'(count_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
